// File: rtl/aes_host_master.sv
// Bus initiator for the AES128 core's word-serial register interface: key/plaintext writes, then a ciphertext read.
// Optional macro AES_HOST_KEY_CACHE_EN skips the key write when key_in matches the last key written.
module aes_host_master #(
  parameter int CORE_LAT = 12,
  parameter int READ_LAT = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] pt_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] ct_out,
  output logic         CS,
  output logic         RW,
  output logic         adress,
  output logic [31:0]  wdata,
  input  logic [31:0]  rdata
);

  localparam int WAIT_MAX = (CORE_LAT > READ_LAT) ? CORE_LAT : READ_LAT;
  localparam int WW       = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] CORE_END = WW'(CORE_LAT - 1);
  localparam logic [WW-1:0] RD_END   = WW'((READ_LAT >= 2) ? (READ_LAT - 2) : 0);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CMD_KEY   = 4'd1,
    S_BEAT_KEY  = 4'd2,
    S_GAP       = 4'd3,
    S_CMD_DATA  = 4'd4,
    S_BEAT_DATA = 4'd5,
    S_WAIT_CORE = 4'd6,
    S_CMD_READ  = 4'd7,
    S_WAIT_RD   = 4'd8,
    S_BEAT_READ = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  state_t          state_r, state_s;
  logic [1:0]      beat_r, beat_s;
  logic [WW-1:0]   wait_r, wait_s;
  logic [127:0]    key_r, pt_r, ct_shift_r, ct_out_r;
  logic [127:0]    ct_shift_s;
  logic            key_hit_s;

  // Selects 32-bit word idx of a 128-bit block, word 0 being the most significant.
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      2'd3:    w = blk[31:0];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  assign ct_shift_s = {ct_shift_r[95:0], rdata};

`ifdef AES_HOST_KEY_CACHE_EN
  logic [127:0] last_key_r;
  logic         key_valid_r;

  assign key_hit_s = key_valid_r && (key_in == last_key_r);

  // The cache is only trusted once a full key write has completed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_key_r  <= 128'd0;
      key_valid_r <= 1'b0;
    end else if (state_r == S_BEAT_KEY && beat_r == 2'd3) begin
      last_key_r  <= key_r;
      key_valid_r <= 1'b1;
    end
  end
`else
  assign key_hit_s = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      beat_r  <= 2'd0;
      wait_r  <= '0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      wait_r  <= wait_s;
    end
  end

  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    wait_s  = wait_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = key_hit_s ? S_CMD_DATA : S_CMD_KEY;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CMD_KEY:  state_s = S_BEAT_KEY;
      S_BEAT_KEY: begin
        beat_s = beat_r + 2'd1;
        if (beat_r == 2'd3) begin
          state_s = S_GAP;
        end else begin
          state_s = S_BEAT_KEY;
        end
      end
      S_GAP:       state_s = S_CMD_DATA;
      S_CMD_DATA:  state_s = S_BEAT_DATA;
      S_BEAT_DATA: begin
        beat_s = beat_r + 2'd1;
        if (beat_r == 2'd3) begin
          state_s = S_WAIT_CORE;
        end else begin
          state_s = S_BEAT_DATA;
        end
      end
      S_WAIT_CORE: begin
        if (wait_r == CORE_END) begin
          wait_s  = '0;
          state_s = S_CMD_READ;
        end else begin
          wait_s  = wait_r + WW'(1);
        end
      end
      S_CMD_READ: begin
        if (READ_LAT > 1) begin
          state_s = S_WAIT_RD;
        end else begin
          state_s = S_BEAT_READ;
        end
      end
      S_WAIT_RD: begin
        if (wait_r == RD_END) begin
          wait_s  = '0;
          state_s = S_BEAT_READ;
        end else begin
          wait_s  = wait_r + WW'(1);
        end
      end
      S_BEAT_READ: begin
        beat_s = beat_r + 2'd1;
        if (beat_r == 2'd3) begin
          state_s = S_DONE;
        end else begin
          state_s = S_BEAT_READ;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: begin
        state_s = S_IDLE;
        beat_s  = 2'd0;
        wait_s  = '0;
      end
    endcase
  end

  // ct_out only changes on the final read beat, so an aborted read never leaks a partial result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_r      <= 128'd0;
      pt_r       <= 128'd0;
      ct_shift_r <= 128'd0;
      ct_out_r   <= 128'd0;
    end else begin
      if (state_r == S_IDLE && start) begin
        key_r <= key_in;
        pt_r  <= pt_in;
      end
      if (state_r == S_BEAT_READ) begin
        ct_shift_r <= ct_shift_s;
        if (beat_r == 2'd3) begin
          ct_out_r <= ct_shift_s;
        end
      end
    end
  end

  always_comb begin
    busy   = (state_r != S_IDLE);
    done   = 1'b0;
    CS     = 1'b0;
    RW     = 1'b0;
    adress = 1'b0;
    wdata  = 32'd0;
    case (state_r)
      S_CMD_KEY: begin
        CS     = 1'b1;
        RW     = 1'b1;
        adress = 1'b1;
      end
      S_BEAT_KEY:  wdata = word_sel(key_r, beat_r);
      S_CMD_DATA: begin
        CS     = 1'b1;
        RW     = 1'b1;
      end
      S_BEAT_DATA: wdata = word_sel(pt_r, beat_r);
      S_CMD_READ:  CS    = 1'b1;
      S_DONE:      done  = 1'b1;
      default: begin
        done   = 1'b0;
        CS     = 1'b0;
      end
    endcase
  end

  assign ct_out = ct_out_r;

endmodule

// File: tb/tb_aes_host_master.sv
// Bench for aes_host_master: randomized transactions checked cycle by cycle against a timeline model.
// Instance a uses default latencies, instance b uses CORE_LAT=1, READ_LAT=1.
module tb_aes_host_master;

  logic         clk = 1'b0;
  logic         reset_n, start, sel;
  logic [127:0] key_in, pt_in;

  logic         busy_a, done_a, cs_a, rw_a, ad_a;
  logic [127:0] ct_a;
  logic [31:0]  wd_a, rd_a;
  logic         busy_b, done_b, cs_b, rw_b, ad_b;
  logic [127:0] ct_b;
  logic [31:0]  wd_b, rd_b;
  logic         start_a, start_b;

  int tests;
  int fails;

  logic [127:0] mk [2];
  bit           mv [2];
  logic [127:0] exp_ct [2];
  logic [31:0]  rd_w [4];

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  aes_host_master #(.CORE_LAT(12), .READ_LAT(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .key_in(key_in), .pt_in(pt_in),
    .busy(busy_a), .done(done_a), .ct_out(ct_a), .CS(cs_a), .RW(rw_a),
    .adress(ad_a), .wdata(wd_a), .rdata(rd_a)
  );

  aes_host_master #(.CORE_LAT(1), .READ_LAT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .key_in(key_in), .pt_in(pt_in),
    .busy(busy_b), .done(done_b), .ct_out(ct_b), .CS(cs_b), .RW(rw_b),
    .adress(ad_b), .wdata(wd_b), .rdata(rd_b)
  );

  wire         o_busy = sel ? busy_b : busy_a;
  wire         o_done = sel ? done_b : done_a;
  wire         o_cs   = sel ? cs_b   : cs_a;
  wire         o_rw   = sel ? rw_b   : rw_a;
  wire         o_ad   = sel ? ad_b   : ad_a;
  wire [31:0]  o_wd   = sel ? wd_b   : wd_a;
  wire [127:0] o_ct   = sel ? ct_b   : ct_a;

  task automatic check(input string tag, input int k, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) rd_w[i] = $urandom;
  endtask

  // Core-side read responder: words appear READ_LAT cycles after the read command, noise otherwise.
  initial begin
    int sa, sb, ca, cb;
    sa = 0; sb = 0;
    rd_a = 32'd0; rd_b = 32'd0;
    forever begin
      @(negedge clk);
      ca = sa; cb = sb;
      rd_a = (ca >= 2 && ca < 6) ? rd_w[ca-2] : $urandom;
      rd_b = (cb >= 1 && cb < 5) ? rd_w[cb-1] : $urandom;
      if (!reset_n) sa = 0; else if (cs_a && !rw_a) sa = 1; else if (ca > 0 && ca < 8) sa = ca + 1; else sa = 0;
      if (!reset_n) sb = 0; else if (cs_b && !rw_b) sb = 1; else if (cb > 0 && cb < 8) sb = cb + 1; else sb = 0;
    end
  end

  // Called at the mid-point of the cycle whose closing edge should accept start.
  task automatic run_txn(input logic [127:0] key, input logic [127:0] pt, input bit hold);
    int cl, rl, off, dcmd, rcmd, rb, dc;
    bit hit, exp_cs, exp_rw, exp_ad;
    logic [31:0]  exp_wd;
    logic [127:0] sh, ct_exp;
    cl = sel ? 1 : 12;
    rl = sel ? 1 : 2;
    hit = 1'b0;
`ifdef AES_HOST_KEY_CACHE_EN
    hit = mv[sel] && (key == mk[sel]);
`endif
    off  = hit ? 6 : 0;
    dcmd = 7 - off;
    rcmd = 12 - off + cl;
    rb   = rcmd + rl;
    dc   = rb + 4;
    ct_exp = {rd_w[0], rd_w[1], rd_w[2], rd_w[3]};
    key_in = key; pt_in = pt; start = 1'b1;
    for (int k = 1; k <= dc + 1; k++) begin
      @(negedge clk);
      exp_cs = (!hit && k == 1) || (k == dcmd) || (k == rcmd);
      exp_rw = (k != rcmd);
      exp_ad = (!hit && k == 1);
      exp_wd = 32'd0;
      if (!hit && k >= 2 && k <= 5) begin
        sh = key >> (96 - 32 * (k - 2));
        exp_wd = sh[31:0];
      end
      if (k >= dcmd + 1 && k <= dcmd + 4) begin
        sh = pt >> (96 - 32 * (k - dcmd - 1));
        exp_wd = sh[31:0];
      end
      if (k == dc) exp_ct[sel] = ct_exp;
      check("busy", k, o_busy, (k <= dc));
      check("done", k, o_done, (k == dc));
      check("cs", k, o_cs, exp_cs);
      if (exp_cs) begin
        check("rw", k, o_rw, exp_rw);
        check("adress", k, o_ad, exp_ad);
      end
      check("wdata", k, o_wd, exp_wd);
      check("ct_out", k, o_ct, exp_ct[sel]);
      if (hold) start = 1'b1;
      else if (k <= dc) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (k <= dc) begin
        key_in = {$urandom, $urandom, $urandom, $urandom};
        pt_in  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (!hit) begin
      mv[sel] = 1'b1;
      mk[sel] = key;
    end
  endtask

  initial begin
    logic [127:0] k1, p1, k2, kr;
    tests = 0; fails = 0;
    sel = 1'b0; start = 1'b0; reset_n = 1'b0;
    key_in = 128'd0; pt_in = 128'd0;
    mv[0] = 1'b0; mv[1] = 1'b0;
    mk[0] = 128'd0; mk[1] = 128'd0;
    exp_ct[0] = 128'd0; exp_ct[1] = 128'd0;
    rand_words();
    repeat (2) @(negedge clk);
    check("rst_busy", 0, busy_a, 1'b0);
    check("rst_done", 0, done_a, 1'b0);
    check("rst_cs", 0, cs_a, 1'b0);
    check("rst_rw", 0, rw_a, 1'b0);
    check("rst_adress", 0, ad_a, 1'b0);
    check("rst_wdata", 0, wd_a, 32'd0);
    check("rst_ct", 0, ct_a, 128'd0);
    check("rst_busy_b", 0, busy_b, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    k1 = 128'h000102030405060708090A0B0C0D0E0F;
    p1 = 128'h00112233445566778899AABBCCDDEEFF;
    rd_w[0] = 32'h69C4E0D8; rd_w[1] = 32'h6A7B0430;
    rd_w[2] = 32'hD8CDB780; rd_w[3] = 32'h70B4C55A;
    run_txn(k1, p1, 1'b0);
    check("known_ct", 0, ct_a, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);

    // Same key with start held high, then a changed key accepted in the first idle cycle.
    rand_words();
    run_txn(k1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    rand_words();
    k2 = {$urandom, $urandom, $urandom, $urandom};
    run_txn(k2, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Reset in the middle of the plaintext beats.
    rand_words();
    key_in = k2; pt_in = p1; start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs", 9, cs_a, 1'b0);
    check("mid_rst_wdata", 9, wd_a, 32'd0);
    check("mid_rst_busy", 9, busy_a, 1'b0);
    check("mid_rst_ct", 9, ct_a, 128'd0);
    mv[0] = 1'b0; mv[1] = 1'b0;
    exp_ct[0] = 128'd0; exp_ct[1] = 128'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rand_words();
    run_txn(k2, p1, 1'b0);

    // Minimum latencies on the second instance.
    sel = 1'b1;
    @(negedge clk);
    rand_words();
    run_txn(k1, p1, 1'b0);
    rand_words();
    run_txn(k1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    sel = 1'b0;
    @(negedge clk);
    kr = k2;
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) kr = {$urandom, $urandom, $urandom, $urandom};
      rand_words();
      run_txn(kr, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
